alu_issue_ctrl: RTL



---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bundle: instruction fields in, ALU operand/result loop, result handshake out.
// slave = issue controller, master = surrounding decode/ALU/writeback side.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            res_taken;
  logic            res_illegal;

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
    input  alu_out, alu_zero, res_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output res_valid, res_data, res_taken, res_illegal
  );

  modport master (
    output in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
    output alu_out, alu_zero, res_ready,
    input  in_ready, alu_a, alu_b, alu_op,
    input  res_valid, res_data, res_taken, res_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage back-pressured ALU issue: decode+register operands (stage 1), capture ALU result
// and resolve BEQ/BNE (stage 2). Retired-op and retired-illegal counters on the result handshake.
module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_if.slave       bus,
  output logic [CNT_W-1:0] ops_cnt,
  output logic [CNT_W-1:0] ill_cnt
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_BEQ  = 2'd1;
  localparam logic [1:0] K_BNE  = 2'd2;
  localparam logic [1:0] K_ILL  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic            s1_valid;
  logic [1:0]      s1_kind;
  logic            s1_adv, accept, res_hs;
  logic [3:0]      d_op;
  logic [XLEN-1:0] d_a, d_b;
  logic [1:0]      d_kind;
  logic            d_taken;

  always_comb begin
    d_op   = OP_ADD;
    d_a    = bus.rs1_val;
    d_b    = bus.rs2_val;
    d_kind = K_NORM;
    case (bus.opcode)
      OPC_R: begin
        case (bus.funct3)
          3'b000:  d_op = bus.funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  d_op = OP_AND;
          3'b110:  d_op = OP_OR;
          default: d_kind = K_ILL;
        endcase
      end
      OPC_I: begin
        d_b = bus.imm;
        case (bus.funct3)
          3'b000:  d_op = OP_ADD;
          3'b111:  d_op = OP_AND;
          3'b110:  d_op = OP_OR;
          default: d_kind = K_ILL;
        endcase
      end
      OPC_LD, OPC_ST: d_b = bus.imm;
      OPC_BR: begin
        d_op = OP_SUB;
        case (bus.funct3)
          3'b000:  d_kind = K_BEQ;
          3'b001:  d_kind = K_BNE;
          default: d_kind = K_ILL;
        endcase
      end
      default: d_kind = K_ILL;
    endcase
    // Illegal encodings issue a harmless ADD of zeros so the ALU result is always 0.
    if (d_kind == K_ILL) begin
      d_op = OP_ADD;
      d_a  = '0;
      d_b  = '0;
    end
  end

  assign s1_adv       = s1_valid & (~bus.res_valid | bus.res_ready);
  assign bus.in_ready = ~flush & (~s1_valid | s1_adv);
  assign accept       = bus.in_valid & bus.in_ready;
  assign res_hs       = bus.res_valid & bus.res_ready;

  always_comb begin
    d_taken = 1'b0;
    case (s1_kind)
      K_BEQ:   d_taken = bus.alu_zero;
      K_BNE:   d_taken = ~bus.alu_zero;
      default: d_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid        <= 1'b0;
      s1_kind         <= K_NORM;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_op      <= OP_ADD;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_taken   <= 1'b0;
      bus.res_illegal <= 1'b0;
      ops_cnt         <= '0;
      ill_cnt         <= '0;
    end else if (flush) begin
      s1_valid      <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_kind    <= d_kind;
        bus.alu_a  <= d_a;
        bus.alu_b  <= d_b;
        bus.alu_op <= d_op;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        bus.res_valid   <= 1'b1;
        bus.res_data    <= (s1_kind == K_ILL) ? '0 : bus.alu_out;
        bus.res_taken   <= d_taken;
        bus.res_illegal <= (s1_kind == K_ILL);
      end else if (bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end

      if (res_hs) begin
        ops_cnt <= ops_cnt + CNT_ONE;
        if (bus.res_illegal) ill_cnt <= ill_cnt + CNT_ONE;
      end
    end
  end
endmodule
